// File: rtl/sonar_dsp_pkg.sv
// Shared sonar DSP widths and the decimator output beat layout.
// Pure declarations: no logic, no latency, no flow control.
package sonar_dsp_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int CH_W       = 3;
    localparam int CH_NUM_MAX = 8;
    localparam int BEAT_W     = SAMPLE_W + CH_W + 1;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic [CH_W-1:0]     user;
        logic                last;
    } beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output FIFO with registered head; a push is visible on out_vld one cycle later.
// in_rdy is registered from next occupancy (high while at most one entry is held), so it never depends on out_rdy combinationally.
module axis_skid_buf #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    always_comb begin
        push    = in_vld;
        pop     = (cnt_q != 2'd0) && out_rdy;
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // slot0 is always the head; slot1 only ever holds the second-oldest beat
        case (cnt_q)
            2'd0: begin
                if (push) slot0_d = in_dat;
            end
            2'd1: begin
                if (push && pop) begin
                    slot0_d = in_dat;
                end else if (push) begin
                    slot1_d = in_dat;
                end
            end
            default: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    if (push) slot1_d = in_dat;
                end
            end
        endcase

        rdy_d = (cnt_d <= 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_rdy  = rdy_q;
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = slot0_q;

endmodule

// File: rtl/decimator_cic1.sv
// Per-channel single-stage CIC decimator (integrate-and-dump by 2**DECIM_LOG2, early dump on tlast).
// Output one cycle after a closing input; s_axis_tready follows the skid buffer's registered space flag.
module decimator_cic1
    import sonar_dsp_pkg::*;
#(
    parameter int DECIM_LOG2 = 3,
    parameter int CH_NUM     = 8
) (
    input  logic                s_axis_aclk,
    input  logic                s_axis_arstn,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [CH_W-1:0]     s_axis_tuser,
    input  logic                s_axis_tlast,
    output logic [SAMPLE_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [CH_W-1:0]     m_axis_tuser,
    output logic                m_axis_tlast
);

    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;
    // A zero-width counter is illegal; with D=1 the single bit simply stays 0.
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic signed [ACC_W-1:0]    acc_q [CH_NUM];
    logic signed [ACC_W-1:0]    acc_d [CH_NUM];
    logic        [CNT_W-1:0]    cnt_q [CH_NUM];
    logic        [CNT_W-1:0]    cnt_d [CH_NUM];

    logic        [CH_W-1:0]     ch;
    logic signed [SAMPLE_W-1:0] sample;
    logic signed [ACC_W-1:0]    sum;
    logic                       in_xfer;
    logic                       win_close;
    logic                       push;
    logic                       buf_rdy;
    beat_t                      beat;
    beat_t                      out_beat;

    always_comb begin
        ch        = s_axis_tuser;
        sample    = s_axis_tdata;
        in_xfer   = s_axis_tvalid && buf_rdy;
        sum       = acc_q[ch] + sample;
        win_close = (cnt_q[ch] == CNT_LAST) || s_axis_tlast;
        push      = in_xfer && win_close;

        // Early tlast closes are still divided by the full D on purpose.
        beat.data = SAMPLE_W'(sum >>> DECIM_LOG2);
        beat.user = ch;
        beat.last = s_axis_tlast;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (in_xfer) begin
            if (win_close) begin
                acc_d[ch] = '0;
                cnt_d[ch] = '0;
            end else begin
                acc_d[ch] = sum;
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            for (int i = 0; i < CH_NUM; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    axis_skid_buf #(
        .W(BEAT_W)
    ) u_out_buf (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_arstn),
        .in_vld  (push),
        .in_dat  (beat),
        .in_rdy  (buf_rdy),
        .out_vld (m_axis_tvalid),
        .out_dat (out_beat),
        .out_rdy (m_axis_tready)
    );

    assign s_axis_tready = buf_rdy;
    assign m_axis_tdata  = out_beat.data;
    assign m_axis_tuser  = out_beat.user;
    assign m_axis_tlast  = out_beat.last;

endmodule

// File: doc/decimator_cic1.md
DECIMATOR_CIC1 -- requirements
Module: decimator_cic1

Interface
REQ-001 Parameter DECIM_LOG2, default 3, log2 of the decimation factor D = 2**DECIM_LOG2; legal range 0..7.
REQ-002 Parameter CH_NUM, default 8, number of interleaved channels carried in tuser.
REQ-003 s_axis_aclk  input  1  single clock for the whole block.
REQ-004 s_axis_arstn  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  24  signed sample from the lowpass stage.
REQ-006 s_axis_tvalid  input  1  input sample valid.
REQ-007 s_axis_tready  output  1  block accepts the input sample.
REQ-008 s_axis_tuser  input  3  channel index 0..CH_NUM-1.
REQ-009 s_axis_tlast  input  1  end of ping frame on this channel.
REQ-010 m_axis_tdata  output  24  signed decimated sample.
REQ-011 m_axis_tvalid  output  1  output sample valid.
REQ-012 m_axis_tready  input  1  downstream accepts the output sample.
REQ-013 m_axis_tuser  output  3  channel index of the output sample.
REQ-014 m_axis_tlast  output  1  output sample closes a frame.

Function
REQ-015 Input transfer occurs when s_axis_tvalid and s_axis_tready are both high on a rising edge; output transfer occurs when m_axis_tvalid and m_axis_tready are both high.
REQ-016 Per channel ch, the block keeps a phase counter cnt[ch] (DECIM_LOG2 bits) and a signed accumulator acc[ch] of 24+DECIM_LOG2 bits.
REQ-017 On an input transfer: sum = acc[ch] + sign-extended tdata; the window closes if cnt[ch] == D-1 or tlast == 1.
REQ-018 On window close, the block enqueues one output word {tdata = sum >>> DECIM_LOG2 (arithmetic, truncating), tuser = ch, tlast = input tlast}, then clears acc[ch] and cnt[ch] to 0.
REQ-019 When the window does not close, acc[ch] <= sum, cnt[ch] <= cnt[ch]+1, and nothing is enqueued.
REQ-020 A tlast-forced early close scales the partial sum by 1/D anyway, with no renormalisation.
REQ-021 With DECIM_LOG2 = 0, every input is forwarded unchanged, including tuser and tlast.
REQ-022 Channels are fully independent; arbitrary tuser interleaving is legal and order is preserved at the output.
REQ-023 Output is buffered in a 2-entry skid buffer; latency from a closing input transfer to m_axis_tvalid high is exactly 1 cycle when the buffer is empty.
REQ-024 s_axis_tready is a registered signal, high when the skid buffer holds at most 1 entry, independent of m_axis_tready in the same cycle.
REQ-025 Inputs that do not close a window are also stalled while s_axis_tready is low; no input is ever dropped.
REQ-026 A simultaneous enqueue and dequeue leaves the occupancy unchanged.
REQ-027 m_axis_tdata, tuser and tlast stay stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-028 A tuser value >= CH_NUM is undefined input; no protection logic is required.

Reset
REQ-029 Assertion of s_axis_arstn low immediately clears all cnt and acc entries, empties the skid buffer, and forces m_axis_tvalid = 0, s_axis_tready = 0, m_axis_tdata = 0, m_axis_tuser = 0 and m_axis_tlast = 0.
REQ-030 s_axis_tready goes high on the first rising edge after reset deasserts.
REQ-031 Reset mid-window discards partial sums; no output is produced for those windows.

Structure
REQ-032 SAMPLE_W = 24, CH_W = 3 and CH_NUM_MAX = 8 reside in the shared package sonar_dsp_pkg.
REQ-033 The 2-entry output buffer is a sub-module axis_skid_buf, parameterised on payload width (24+3+1).
REQ-034 The per-channel acc and cnt state is held in register arrays indexed by tuser; read-modify-write completes in one cycle.

Verification
REQ-035 D=8, ch0 fed 1..8 with m_ready=1 -> one output, tdata=4 (36>>>3), tuser=0, tlast=0.
REQ-036 D=8, ch2 fed -1 x8 -> tdata=-1; ch2 fed 100,200,300 with tlast on 300 -> tdata=75, tlast=1, and cnt[2] restarts at 0.
REQ-037 D=8, channels 0..7 round-robin with ch k sample = 1000*k for 64 beats -> 8 outputs, in order ch0..ch7, tdata=1000*k each.
REQ-038 Hold m_ready=0 with D=1 and 3 inputs -> 2 outputs buffered, s_ready low after the 2nd; releasing m_ready yields all 3 outputs in order, with no loss or duplication.
REQ-039 D=8, assert reset after 5 samples on ch1, release, then feed 8 samples of 8 -> single output tdata=8, with no stale sum.
REQ-040 Random tvalid/tready back-pressure with 10k samples over 8 channels -> output stream matches the reference model bit-exactly.
